// File: rtl/sel_key_ctrl.sv
// Debounced key toggle controller: drives the registered 2:1 mux select and a per-press strobe.
// Optional long-hold clear of the select is enabled by defining SEL_HOLD_CLR_EN.
module sel_key_ctrl #(
  parameter logic [19:0] CNT_MAX  = 20'd999_999,
  parameter logic [26:0] HOLD_MAX = 27'd99_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic sel,
  output logic key_flag
);

  localparam int CW_RAW = $clog2(32'(CNT_MAX) + 32'd1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_LIM = CNT_MAX[CW-1:0];

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      sync_q;
  logic            sel_q;
  logic            flag_q;
  logic            key_s;

  // A zero hold threshold would clear the select one cycle after every accept.
  if (HOLD_MAX == 27'd0) begin : g_hold_chk
    $error("sel_key_ctrl: HOLD_MAX must be non-zero");
  end

`ifdef SEL_HOLD_CLR_EN
  localparam int HW_RAW = $clog2(32'(HOLD_MAX) + 32'd1);
  localparam int HW     = (HW_RAW < 1) ? 1 : HW_RAW;
  localparam logic [HW-1:0] HOLD_LIM = HOLD_MAX[HW-1:0];

  logic [HW-1:0] hold_q;
  logic          hold_done_q;
`endif

  assign key_s    = sync_q[1];
  assign sel      = sel_q;
  assign key_flag = flag_q;

  // Two-flop synchroniser for the asynchronous key; resets to the released level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_in};
    end
  end

  // Debounce FSM with registered select and strobe outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      flag_q      <= 1'b0;
`ifdef SEL_HOLD_CLR_EN
      hold_q      <= '0;
      hold_done_q <= 1'b0;
`endif
    end else begin
      flag_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!key_s) begin
            state_q <= PRESS_FILT;
            cnt_q   <= '0;
          end
        end
        PRESS_FILT: begin
          if (key_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q < CNT_LIM) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            state_q <= DOWN;
            flag_q  <= 1'b1;
            sel_q   <= ~sel_q;
            cnt_q   <= '0;
`ifdef SEL_HOLD_CLR_EN
            hold_q      <= '0;
            hold_done_q <= 1'b0;
`endif
          end
        end
        DOWN: begin
          if (key_s) begin
            state_q <= REL_FILT;
            cnt_q   <= '0;
          end
`ifdef SEL_HOLD_CLR_EN
          // Hold clear fires once, on the cycle after the count saturates.
          else if (hold_q < HOLD_LIM) begin
            hold_q <= hold_q + HW'(1);
          end else if (!hold_done_q) begin
            sel_q       <= 1'b0;
            hold_done_q <= 1'b1;
          end
`endif
        end
        REL_FILT: begin
          if (!key_s) begin
            state_q <= DOWN;
            cnt_q   <= '0;
`ifdef SEL_HOLD_CLR_EN
            hold_q  <= '0;
`endif
          end else if (cnt_q < CNT_LIM) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sel_key_ctrl.sv
// Directed bench for sel_key_ctrl with CNT_MAX=9, HOLD_MAX=49; key driven and outputs sampled on the falling edge.
// Expectations for the hold-clear step follow whether SEL_HOLD_CLR_EN is defined.
module tb_sel_key_ctrl;

  logic sys_clk;
  logic sys_rst_n;
  logic key_in;
  logic sel;
  logic key_flag;

  int n_cmp;
  int n_fail;
  int flag_cnt;
  int fc0;
  logic exp_sel;

  sel_key_ctrl #(
    .CNT_MAX  (20'd9),
    .HOLD_MAX (27'd49)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .sel       (sel),
    .key_flag  (key_flag)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Strobe counter: sampled at the rising edge, so each one-cycle pulse counts once.
  always @(posedge sys_clk) begin
    if (key_flag === 1'b1) flag_cnt = flag_cnt + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    flag_cnt = 0;
    sys_rst_n = 1'b0;
    key_in    = 1'b0;

    // Reset held with key pressed: outputs stay low.
    for (int i = 0; i < 3; i++) begin
      wait_cyc(1);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_flag", 32'(key_flag), 32'd0);
    end
    sys_rst_n = 1'b1;
    wait_cyc(12);
    check("post_rst_pre_sel", 32'(sel), 32'd0);
    wait_cyc(1);
    check("post_rst_toggle_sel", 32'(sel), 32'd1);
    check("post_rst_toggle_flag", 32'(key_flag), 32'd1);
    wait_cyc(1);
    check("post_rst_flag_drop", 32'(key_flag), 32'd0);
    key_in = 1'b1;
    wait_cyc(25);
    check("post_rst_release_sel", 32'(sel), 32'd1);
    check("post_rst_flag_cnt", 32'(flag_cnt), 32'd1);

    // Reset mid-debounce clears sel asynchronously and discards the press.
    fc0 = flag_cnt;
    key_in = 1'b0;
    wait_cyc(8);
    #1 sys_rst_n = 1'b0;
    #1;
    check("async_rst_sel", 32'(sel), 32'd0);
    check("async_rst_flag", 32'(key_flag), 32'd0);
    wait_cyc(1);
    key_in    = 1'b1;
    sys_rst_n = 1'b1;
    wait_cyc(20);
    check("discard_sel", 32'(sel), 32'd0);
    check("discard_flag_cnt", 32'(flag_cnt), 32'(fc0));

    // Clean press from sel=0, held 30 cycles.
    fc0 = flag_cnt;
    key_in = 1'b0;
    wait_cyc(12);
    check("clean_pre_sel", 32'(sel), 32'd0);
    check("clean_pre_flag", 32'(key_flag), 32'd0);
    wait_cyc(1);
    check("clean_sel", 32'(sel), 32'd1);
    check("clean_flag", 32'(key_flag), 32'd1);
    wait_cyc(1);
    check("clean_flag_drop", 32'(key_flag), 32'd0);
    wait_cyc(16);
    key_in = 1'b1;
    wait_cyc(25);
    check("clean_release_sel", 32'(sel), 32'd1);
    check("clean_flag_cnt", 32'(flag_cnt), 32'(fc0 + 1));

    // Bouncy press: low 5, high 1, low 5, high 1, then low 30.
    fc0 = flag_cnt;
    key_in = 1'b0; wait_cyc(5);
    key_in = 1'b1; wait_cyc(1);
    key_in = 1'b0; wait_cyc(5);
    key_in = 1'b1; wait_cyc(1);
    check("bounce_early_flag_cnt", 32'(flag_cnt), 32'(fc0));
    key_in = 1'b0;
    wait_cyc(12);
    check("bounce_pre_sel", 32'(sel), 32'd1);
    wait_cyc(1);
    check("bounce_sel", 32'(sel), 32'd0);
    check("bounce_flag", 32'(key_flag), 32'd1);
    wait_cyc(17);
    check("bounce_flag_cnt", 32'(flag_cnt), 32'(fc0 + 1));

    // Release bounce while still down: high 3, low 2, high 20.
    fc0 = flag_cnt;
    key_in = 1'b1; wait_cyc(3);
    key_in = 1'b0; wait_cyc(2);
    key_in = 1'b1; wait_cyc(20);
    check("rel_bounce_sel", 32'(sel), 32'd0);
    check("rel_bounce_flag_cnt", 32'(flag_cnt), 32'(fc0));

    // Four presses 40 cycles apart: sel goes 1,0,1,0.
    fc0 = flag_cnt;
    exp_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_in = 1'b0;
      wait_cyc(12);
      check("multi_pre_sel", 32'(sel), 32'(exp_sel));
      exp_sel = ~exp_sel;
      wait_cyc(2);
      check("multi_sel", 32'(sel), 32'(exp_sel));
      wait_cyc(6);
      key_in = 1'b1;
      wait_cyc(20);
    end
    check("multi_flag_cnt", 32'(flag_cnt), 32'(fc0 + 4));

    // Long hold from sel=0 for 80 cycles.
`ifdef SEL_HOLD_CLR_EN
    exp_sel = 1'b0;
`else
    exp_sel = 1'b1;
`endif
    fc0 = flag_cnt;
    key_in = 1'b0;
    wait_cyc(13);
    check("hold_accept_sel", 32'(sel), 32'd1);
    wait_cyc(49);
    check("hold_pre_clear_sel", 32'(sel), 32'd1);
    wait_cyc(1);
    check("hold_clear_sel", 32'(sel), 32'(exp_sel));
    check("hold_clear_flag", 32'(key_flag), 32'd0);
    wait_cyc(17);
    key_in = 1'b1;
    wait_cyc(25);
    check("hold_final_sel", 32'(sel), 32'(exp_sel));
    check("hold_flag_cnt", 32'(flag_cnt), 32'(fc0 + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
